// File: rtl/arith_pkg.sv
// Shared arithmetic types: the NZCV flag bundle used by the ALU/multiplier
// datapath and the occupancy encoding of the writeback elastic buffer.
package arith_pkg;

    typedef struct packed {
        logic n;
        logic z;
        logic c;
        logic v;
    } flags_t;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } wb_state_t;

    function automatic flags_t pack_flags(input logic n, input logic z,
                                          input logic c, input logic v);
        flags_t f;
        f.n = n;
        f.z = z;
        f.c = c;
        f.v = v;
        return f;
    endfunction

endpackage

// File: rtl/skid_buffer.sv
// Generic 2-entry elastic buffer (head + skid registers) with valid/ready on
// both sides; in_ready depends only on registered occupancy.
module skid_buffer
    import arith_pkg::*;
#(
    parameter int width = 9
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [width-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [width-1:0] out_data
);

    wb_state_t        state_q, state_d;
    logic [width-1:0] head_q, head_d;
    logic [width-1:0] skid_q, skid_d;
    logic             in_fire_s;
    logic             out_fire_s;

    assign in_ready  = (state_q != FULL);
    assign out_valid = (state_q != EMPTY);
    assign out_data  = head_q;

    // Occupancy next-state and head/skid data steering.
    always_comb begin
        state_d    = state_q;
        head_d     = head_q;
        skid_d     = skid_q;
        in_fire_s  = in_valid & in_ready;
        out_fire_s = out_valid & out_ready;
        if (flush) begin
            state_d = EMPTY;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (in_fire_s) begin
                        head_d  = in_data;
                        state_d = ONE;
                    end else begin
                        state_d = EMPTY;
                    end
                end
                ONE: begin
                    if (in_fire_s && out_fire_s) begin
                        head_d  = in_data;
                        state_d = ONE;
                    end else if (in_fire_s) begin
                        skid_d  = in_data;
                        state_d = FULL;
                    end else if (out_fire_s) begin
                        state_d = EMPTY;
                    end else begin
                        state_d = ONE;
                    end
                end
                FULL: begin
                    // No input can be accepted here, so the skid entry simply moves up.
                    if (out_fire_s) begin
                        head_d  = skid_q;
                        state_d = ONE;
                    end else begin
                        state_d = FULL;
                    end
                end
                default: begin
                    state_d = EMPTY;
                end
            endcase
        end
    end

    // Occupancy and entry registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= EMPTY;
            head_q  <= {width{1'b0}};
            skid_q  <= {width{1'b0}};
        end else begin
            state_q <= state_d;
            head_q  <= head_d;
            skid_q  <= skid_d;
        end
    end

endmodule

// File: rtl/mul_wb_stage.sv
// Registered writeback stage behind the multiplier: buffers {result, flags,
// flag_we} in a skid buffer and updates the architectural NZCV register on commit.
module mul_wb_stage
    import arith_pkg::*;
#(
    parameter int bus = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [bus-1:0] in_result,
    input  logic           in_overflow,
    input  logic           in_zero,
    input  logic           in_negative,
    input  logic           in_carry,
    input  logic           in_flag_we,
    input  logic           flush,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [bus-1:0] out_result,
    output logic [3:0]     out_flags,
    output logic [3:0]     status
);

    localparam int EntryW = bus + 5;

    flags_t            in_flags_s;
    flags_t            head_flags_s;
    logic [EntryW-1:0] in_entry_s;
    logic [EntryW-1:0] head_entry_s;
    logic              head_we_s;
    logic              commit_s;
    flags_t            status_q, status_d;

    // Flags travel untouched; the upstream zero flag means operand-zero.
    assign in_flags_s = pack_flags(in_negative, in_zero, in_carry, in_overflow);
    assign in_entry_s = {in_result, in_flags_s, in_flag_we};

    skid_buffer #(
        .width(EntryW)
    ) u_skid (
        .clk      (clk),
        .rst_n    (rst_n),
        .flush    (flush),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_entry_s),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (head_entry_s)
    );

    assign out_result   = head_entry_s[EntryW-1:5];
    assign head_flags_s = head_entry_s[4:1];
    assign head_we_s    = head_entry_s[0];
    assign out_flags    = head_flags_s;
    assign status       = status_q;

    // A flushed head never commits, so it cannot touch the status register.
    always_comb begin
        commit_s = out_valid & out_ready & ~flush;
        if (commit_s && head_we_s) begin
            status_d = head_flags_s;
        end else begin
            status_d = status_q;
        end
    end

    // Architectural NZCV register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            status_q <= 4'b0000;
        end else begin
            status_q <= status_d;
        end
    end

endmodule

// File: tb/tb_mul_wb_stage.sv
// Directed bench for mul_wb_stage: a vector table for single-cycle behaviour
// plus hand-written backpressure, streaming, flush and reset sequences.
module tb_mul_wb_stage;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] in_result;
    logic       in_overflow;
    logic       in_zero;
    logic       in_negative;
    logic       in_carry;
    logic       in_flag_we;
    logic       flush;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] out_result;
    logic [3:0] out_flags;
    logic [3:0] status;

    int checks = 0;
    int errors = 0;

    int src_q[$];
    int exp_q[$];

    typedef struct {
        logic       iv;
        logic [3:0] res;
        logic [3:0] fl;
        logic       we;
        logic       ordy;
        logic       ir_e;
        logic       ov_e;
        logic [3:0] res_e;
        logic [3:0] fl_e;
        logic [3:0] st_e;
    } vec_t;

    vec_t vecs[5];

    mul_wb_stage #(.bus(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_result  (in_result),
        .in_overflow(in_overflow),
        .in_zero    (in_zero),
        .in_negative(in_negative),
        .in_carry   (in_carry),
        .in_flag_we (in_flag_we),
        .flush      (flush),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_flags  (out_flags),
        .status     (status)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic iv, input logic [3:0] res, input logic [3:0] fl,
                         input logic we, input logic ordy);
        in_valid    = iv;
        in_result   = res;
        in_negative = fl[3];
        in_zero     = fl[2];
        in_carry    = fl[1];
        in_overflow = fl[0];
        in_flag_we  = we;
        out_ready   = ordy;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Feed src_q and collect committed results against exp_q; mode 1 toggles out_ready.
    task automatic run_stream(input int mode, input int max_cycles);
        int cyc;
        cyc = 0;
        while ((src_q.size() > 0 || exp_q.size() > 0) && cyc < max_cycles) begin
            drive(src_q.size() > 0, (src_q.size() > 0) ? 4'(src_q[0]) : 4'd0,
                  4'b0000, 1'b0, (mode == 1) ? (cyc % 2 == 0) : 1'b1);
            #1;
            if (out_valid && out_ready) begin
                if (exp_q.size() > 0) begin
                    chk("stream_order", 8'(out_result), 8'(exp_q.pop_front()));
                end else begin
                    chk("stream_extra_output", 8'(out_valid), 8'd0);
                end
            end
            if (in_valid && in_ready) begin
                void'(src_q.pop_front());
            end
            step();
            cyc++;
        end
        chk("stream_drained", 8'(exp_q.size()), 8'd0);
        drive(1'b0, 4'd0, 4'b0000, 1'b0, 1'b1);
    endtask

    initial begin
        vecs[0] = '{1'b1, 4'hF, 4'b1000, 1'b1, 1'b1, 1'b1, 1'b1, 4'hF, 4'b1000, 4'b0000};
        vecs[1] = '{1'b1, 4'h6, 4'b0000, 1'b0, 1'b1, 1'b1, 1'b1, 4'h6, 4'b0000, 4'b1000};
        vecs[2] = '{1'b1, 4'h0, 4'b0011, 1'b1, 1'b1, 1'b1, 1'b1, 4'h0, 4'b0011, 4'b1000};
        vecs[3] = '{1'b0, 4'h0, 4'b0000, 1'b0, 1'b1, 1'b1, 1'b0, 4'h0, 4'b0000, 4'b0011};
        vecs[4] = '{1'b0, 4'h0, 4'b0000, 1'b0, 1'b0, 1'b1, 1'b0, 4'h0, 4'b0000, 4'b0011};

        rst_n = 1'b0;
        flush = 1'b0;
        drive(1'b0, 4'd0, 4'b0000, 1'b0, 1'b1);
        #12;
        chk("reset_out_valid", 8'(out_valid), 8'd0);
        chk("reset_in_ready", 8'(in_ready), 8'd1);
        chk("reset_out_result", 8'(out_result), 8'd0);
        chk("reset_out_flags", 8'(out_flags), 8'd0);
        chk("reset_status", 8'(status), 8'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        // Table: single transfer, flag_we=0 hold, overflow passthrough with z kept 0.
        for (int i = 0; i < 5; i++) begin
            drive(vecs[i].iv, vecs[i].res, vecs[i].fl, vecs[i].we, vecs[i].ordy);
            step();
            chk($sformatf("vec%0d_in_ready", i), 8'(in_ready), 8'(vecs[i].ir_e));
            chk($sformatf("vec%0d_out_valid", i), 8'(out_valid), 8'(vecs[i].ov_e));
            if (vecs[i].ov_e) begin
                chk($sformatf("vec%0d_out_result", i), 8'(out_result), 8'(vecs[i].res_e));
                chk($sformatf("vec%0d_out_flags", i), 8'(out_flags), 8'(vecs[i].fl_e));
            end
            chk($sformatf("vec%0d_status", i), 8'(status), 8'(vecs[i].st_e));
        end

        // Backpressure: 0 and 1 absorbed, 2 stalls, then drain in order.
        drive(1'b1, 4'd0, 4'b0000, 1'b0, 1'b0);
        step();
        chk("bp_one_in_ready", 8'(in_ready), 8'd1);
        chk("bp_one_out_result", 8'(out_result), 8'd0);
        drive(1'b1, 4'd1, 4'b0000, 1'b0, 1'b0);
        step();
        chk("bp_full_in_ready", 8'(in_ready), 8'd0);
        chk("bp_full_out_valid", 8'(out_valid), 8'd1);
        drive(1'b1, 4'd2, 4'b0000, 1'b0, 1'b0);
        step();
        chk("bp_stall_in_ready", 8'(in_ready), 8'd0);
        chk("bp_stall_head", 8'(out_result), 8'd0);
        src_q = '{2, 3};
        exp_q = '{0, 1, 2, 3};
        run_stream(0, 100);
        chk("bp_status_kept", 8'(status), 8'b0011);

        // Continuous stream with out_ready toggling.
        src_q = '{5, 9, 10, 3, 12, 7};
        exp_q = '{5, 9, 10, 3, 12, 7};
        run_stream(1, 100);

        // Flush from FULL with both handshakes offered.
        drive(1'b1, 4'hA, 4'b0101, 1'b1, 1'b0);
        step();
        drive(1'b1, 4'hB, 4'b0101, 1'b1, 1'b0);
        step();
        chk("pre_flush_full", 8'(in_ready), 8'd0);
        drive(1'b1, 4'hC, 4'b0101, 1'b1, 1'b1);
        flush = 1'b1;
        step();
        flush = 1'b0;
        drive(1'b0, 4'h0, 4'b0000, 1'b0, 1'b1);
        chk("flush_out_valid", 8'(out_valid), 8'd0);
        chk("flush_in_ready", 8'(in_ready), 8'd1);
        chk("flush_status", 8'(status), 8'b0011);
        step();
        chk("flush_input_dropped", 8'(out_valid), 8'd0);
        chk("flush_status_later", 8'(status), 8'b0011);

        // Asynchronous reset mid-stream.
        drive(1'b1, 4'h9, 4'b1010, 1'b1, 1'b0);
        step();
        chk("pre_reset_valid", 8'(out_valid), 8'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_reset_out_valid", 8'(out_valid), 8'd0);
        chk("async_reset_in_ready", 8'(in_ready), 8'd1);
        chk("async_reset_out_result", 8'(out_result), 8'd0);
        chk("async_reset_out_flags", 8'(out_flags), 8'd0);
        chk("async_reset_status", 8'(status), 8'd0);
        drive(1'b0, 4'h0, 4'b0000, 1'b0, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
